cache_line_xfer: RTL

Line-transfer sequencer that drives the index/write port of a cache data RAM array (combinational read, single-cycle write). It moves whole lines between that array and the memory bus. Writeback reads a line out of the array and transmits it as beats. Refill receives beats, assembles a line and writes it into the array. The cache controller issues one command at a time over a valid/ready request port.

---
 rtl/cache_line_xfer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/cache_line_xfer.sv
// Line-transfer sequencer between a cache data RAM (combinational read, one-cycle write)
// and a beat-oriented memory bus: writeback streams a line out, refill assembles one in.
module cache_line_xfer #(
   parameter int INDEX_W = 7,
   parameter int LINE_W  = 64,
   parameter int BEAT_W  = 32,
   parameter int ADDR_W  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_op,
   input  logic [INDEX_W-1:0] req_index,
   input  logic [ADDR_W-1:0]  req_wb_addr,
   input  logic [ADDR_W-1:0]  req_rf_addr,
   output logic [INDEX_W-1:0] ram_index,
   output logic               ram_wen,
   output logic [LINE_W-1:0]  ram_wdata,
   input  logic [LINE_W-1:0]  ram_rdata,
   output logic               mem_w_valid,
   input  logic               mem_w_ready,
   output logic [ADDR_W-1:0]  mem_w_addr,
   output logic [BEAT_W-1:0]  mem_w_data,
   output logic               mem_w_last,
   output logic               mem_ar_valid,
   input  logic               mem_ar_ready,
   output logic [ADDR_W-1:0]  mem_ar_addr,
   input  logic               mem_r_valid,
   output logic               mem_r_ready,
   input  logic [BEAT_W-1:0]  mem_r_data,
   input  logic               mem_r_last,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int BEATS = LINE_W / BEAT_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0]  LAST_K     = CNT_W'(BEATS - 1);
   localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(BEAT_W / 8);

   typedef enum logic [2:0] {
      IDLE,
      WB_LOAD,
      WB_SEND,
      RF_REQ,
      RF_RECV,
      RF_WRITE,
      DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic [1:0]          op_q, op_d;
   logic [INDEX_W-1:0]  index_q, index_d;
   logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
   logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
   logic                err_q, err_d;

   logic                accept;
   logic                cnt_at_last;
   logic [BEAT_W-1:0]   beat_sel;

   assign accept      = req_valid && req_ready;
   assign cnt_at_last = (cnt_q == LAST_K);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         line_q    <= '0;
         op_q      <= '0;
         index_q   <= '0;
         wb_addr_q <= '0;
         rf_addr_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         line_q    <= line_d;
         op_q      <= op_d;
         index_q   <= index_d;
         wb_addr_q <= wb_addr_d;
         rf_addr_q <= rf_addr_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      line_d    = line_q;
      op_d      = op_q;
      index_d   = index_q;
      wb_addr_d = wb_addr_q;
      rf_addr_d = rf_addr_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d      = req_op;
               index_d   = req_index;
               wb_addr_d = req_wb_addr;
               rf_addr_d = req_rf_addr;
               err_d     = 1'b0;
               case (req_op)
                  2'b01, 2'b11: state_d = WB_LOAD;
                  2'b10:        state_d = RF_REQ;
                  default:      state_d = DONE;
               endcase
            end
         end
         WB_LOAD: begin
            line_d  = ram_rdata;
            cnt_d   = '0;
            state_d = WB_SEND;
         end
         WB_SEND: begin
            if (mem_w_ready) begin
               if (cnt_at_last) begin
                  state_d = (op_q == 2'b11) ? RF_REQ : DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         RF_REQ: begin
            if (mem_ar_ready) begin
               cnt_d   = '0;
               line_d  = '0;
               state_d = RF_RECV;
            end
         end
         RF_RECV: begin
            if (mem_r_valid) begin
               for (int i = 0; i < BEATS; i++) begin
                  if (cnt_q == CNT_W'(i)) begin
                     line_d[i*BEAT_W +: BEAT_W] = mem_r_data;
                  end
               end
               // Early last and a missing last on the final slot are both protocol errors.
               if (cnt_at_last || mem_r_last) begin
                  err_d   = err_q | (cnt_at_last ^ mem_r_last);
                  state_d = RF_WRITE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         RF_WRITE: state_d = DONE;
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      beat_sel = '0;
      for (int i = 0; i < BEATS; i++) begin
         if (cnt_q == CNT_W'(i)) begin
            beat_sel = line_q[i*BEAT_W +: BEAT_W];
         end
      end
   end

   // Every control output is forced low while reset is held, whatever the state register holds.
   always_comb begin
      req_ready    = (state_q == IDLE) && !rst;
      busy         = (state_q != IDLE) && !rst;
      done         = (state_q == DONE) && !rst;
      err          = (state_q == DONE) && err_q && !rst;
      ram_wen      = (state_q == RF_WRITE) && !rst;
      mem_w_valid  = (state_q == WB_SEND) && !rst;
      mem_ar_valid = (state_q == RF_REQ) && !rst;
      mem_r_ready  = (state_q == RF_RECV) && !rst;
      ram_index    = (state_q == IDLE) ? req_index : index_q;
      ram_wdata    = line_q;
      mem_w_data   = beat_sel;
      mem_w_last   = cnt_at_last;
      mem_w_addr   = wb_addr_q + ADDR_W'(cnt_q) * BEAT_BYTES;
      mem_ar_addr  = rf_addr_q;
   end

endmodule
